// File: rtl/lc3b_pkg.sv
// Shared definitions for the LC-3b memory bus port: access FSM states,
// byte write-enable encodings, access size constants and the write-enable
// encoder used when an access is started.
package lc3b_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_e;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_LO   = 2'b01;
  localparam logic [1:0] WE_HI   = 2'b10;
  localparam logic [1:0] WE_WORD = 2'b11;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  // Byte enables for a new access: none on reads, both for word stores,
  // and the lane selected by address bit 0 for byte stores.
  function automatic logic [1:0] we_encode(input logic rw, input logic size, input logic a0);
    logic [1:0] we;
    if (rw == 1'b0) begin
      we = WE_NONE;
    end else if (size == SIZE_WORD) begin
      we = WE_WORD;
    end else if (a0 == 1'b1) begin
      we = WE_HI;
    end else begin
      we = WE_LO;
    end
    return we;
  endfunction

endpackage

// File: rtl/mem_bus_port_if.sv
// Memory-side handshake of the bus port. The port drives the request side
// (master); the memory model or controller answers (slave).
interface mem_bus_port_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [1:0]  mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_we,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/mem_bus_port_mdr_format.sv
// mdr_format: formats MDR for the MDR bus gate. Word accesses pass MDR
// through; byte accesses pick the lane addressed by MAR[0] and sign-extend.
module mdr_format
  import lc3b_pkg::*;
(
  input  logic [15:0] mdr_i,
  input  logic        hi_byte_i,
  input  logic        size_i,
  output logic [15:0] mdr_fmt_o
);

  logic [7:0] byte_s;

  // Lane select and sign extension.
  always_comb begin
    byte_s    = 8'h00;
    mdr_fmt_o = 16'h0000;
    if (hi_byte_i == 1'b1) begin
      byte_s = mdr_i[15:8];
    end else begin
      byte_s = mdr_i[7:0];
    end
    if (size_i == SIZE_WORD) begin
      mdr_fmt_o = mdr_i;
    end else begin
      mdr_fmt_o = {{8{byte_s[7]}}, byte_s};
    end
  end

endmodule

// File: rtl/mem_bus_port.sv
// mem_bus_port: receiving end of the 16-bit datapath bus. Holds MAR/MDR,
// runs the IDLE -> ACCESS -> DONE memory handshake and raises R (ready)
// for the control state machine.
// Optional feature: define MEM_TIMEOUT_EN to abort an ACCESS that sees no
// mem_ready within TIMEOUT_CYCLES cycles and set the sticky error flag.
module mem_bus_port
  import lc3b_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [15:0]           bus_i,
  input  logic                  ld_mar_i,
  input  logic                  ld_mdr_i,
  input  logic                  mio_en_i,
  input  logic                  r_w_i,
  input  logic                  data_size_i,
  mem_bus_port_if.master        mem,
  output logic [15:0]           mar_o,
  output logic [15:0]           mdr_o,
  output logic [15:0]           mdr_fmt_o,
  output logic                  ready_o,
  output logic                  error_o
);

  state_e      state_q, state_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic [15:0] addr_q, addr_d;
  logic [1:0]  we_q, we_d;
  logic        rw_q, rw_d;
  logic        size_q, size_d;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             error_q, error_d;
`else
  logic [31:0] unused_timeout_s;
  assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
`endif

  // Next-state logic: register loads from the bus and the access FSM.
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    addr_d  = addr_q;
    we_d    = we_q;
    rw_d    = rw_q;
    size_d  = size_q;
`ifdef MEM_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    error_d   = error_q;
`endif

    if (ld_mar_i == 1'b1) begin
      mar_d = bus_i;
    end else begin
      mar_d = mar_q;
    end

    // While mio_en is high MDR belongs to the memory read path.
    if ((ld_mdr_i == 1'b1) && (mio_en_i == 1'b0)) begin
      size_d = data_size_i;
      if (data_size_i == SIZE_WORD) begin
        mdr_d = bus_i;
      end else begin
        mdr_d = {bus_i[7:0], bus_i[7:0]};
      end
    end else begin
      mdr_d = mdr_q;
    end

    case (state_q)
      IDLE: begin
        if (mio_en_i == 1'b1) begin
          // Uses the current MAR, so a same-edge ld_mar affects only later accesses.
          rw_d    = r_w_i;
          size_d  = data_size_i;
          addr_d  = {mar_q[15:1], 1'b0};
          we_d    = we_encode(r_w_i, data_size_i, mar_q[0]);
          state_d = ACCESS;
`ifdef MEM_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (mem.mem_ready == 1'b1) begin
          if (rw_q == 1'b0) begin
            mdr_d = mem.mem_rdata;
          end else begin
            mdr_d = mdr_q;
          end
          we_d    = WE_NONE;
          state_d = DONE;
        end else begin
`ifdef MEM_TIMEOUT_EN
          if (tmo_cnt_q == CNT_LAST) begin
            we_d    = WE_NONE;
            error_d = 1'b1;
            state_d = DONE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
            state_d   = ACCESS;
          end
`else
          state_d = ACCESS;
`endif
        end
      end
      DONE: begin
        if (mio_en_i == 1'b0) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        we_d    = WE_NONE;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i == 1'b1) begin
      state_q <= IDLE;
      mar_q   <= 16'h0000;
      mdr_q   <= 16'h0000;
      addr_q  <= 16'h0000;
      we_q    <= WE_NONE;
      rw_q    <= 1'b0;
      size_q  <= SIZE_WORD;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_q <= '0;
      error_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      error_q   <= error_d;
`endif
    end
  end

  mdr_format u_mdr_format (
    .mdr_i     (mdr_q),
    .hi_byte_i (mar_q[0]),
    .size_i    (size_q),
    .mdr_fmt_o (mdr_fmt_o)
  );

  assign mem.mem_req   = (state_q == ACCESS);
  assign mem.mem_addr  = addr_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_wdata = mdr_q;
  assign mar_o         = mar_q;
  assign mdr_o         = mdr_q;
  assign ready_o       = (state_q == DONE);
`ifdef MEM_TIMEOUT_EN
  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_port.sv
// Self-checking bench for mem_bus_port. Expected request (address/enables)
// and expected MDR per access are queued when an access is launched and
// compared by a monitor when mem_req / ready rise.
module tb_mem_bus_port;
  import lc3b_pkg::*;

  logic        clock;
  logic        reset;
  logic [15:0] bus;
  logic        ld_mar, ld_mdr, mio_en, r_w, data_size;
  logic [15:0] mar, mdr, mdr_fmt;
  logic        ready, error;

  int n_checks = 0;
  int n_pass   = 0;

  logic [17:0] req_q[$];
  logic [15:0] rsp_q[$];

  mem_bus_port_if mem_if ();

  mem_bus_port #(.TIMEOUT_CYCLES(4)) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .bus_i       (bus),
    .ld_mar_i    (ld_mar),
    .ld_mdr_i    (ld_mdr),
    .mio_en_i    (mio_en),
    .r_w_i       (r_w),
    .data_size_i (data_size),
    .mem         (mem_if),
    .mar_o       (mar),
    .mdr_o       (mdr),
    .mdr_fmt_o   (mdr_fmt),
    .ready_o     (ready),
    .error_o     (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: compare queued expectations when mem_req and ready rise.
  logic req_prev = 1'b0;
  logic rdy_prev = 1'b0;
  always @(negedge clock) begin
    logic [17:0] e;
    logic [15:0] m;
    if (mem_if.mem_req && !req_prev) begin
      if (req_q.size() == 0) begin
        check_val("unexpected_req", 16'd1, 16'd0);
      end else begin
        e = req_q.pop_front();
        check_val("req_addr", mem_if.mem_addr, e[17:2]);
        check_val("req_we", {14'd0, mem_if.mem_we}, {14'd0, e[1:0]});
      end
    end
    if (ready && !rdy_prev) begin
      if (rsp_q.size() == 0) begin
        check_val("unexpected_ready", 16'd1, 16'd0);
      end else begin
        m = rsp_q.pop_front();
        check_val("rsp_mdr", mdr, m);
      end
    end
    req_prev = mem_if.mem_req;
    rdy_prev = ready;
  end

  task automatic load_mar(input logic [15:0] v);
    bus = v; ld_mar = 1'b1;
    step();
    ld_mar = 1'b0;
  endtask

  // Full access: mem_ready arrives lat cycles after mem_req rises.
  task automatic access(input logic rw, input logic sz, input logic [15:0] rdata, input int lat,
                        input logic [15:0] exp_addr, input logic [1:0] exp_we, input logic [15:0] exp_mdr);
    req_q.push_back({exp_addr, exp_we});
    rsp_q.push_back(exp_mdr);
    r_w = rw; data_size = sz; mem_if.mem_rdata = rdata; mio_en = 1'b1;
    step();
    check_val("req_high", {15'd0, mem_if.mem_req}, 16'd1);
    repeat (lat - 1) step();
    mem_if.mem_ready = 1'b1;
    step();
    mem_if.mem_ready = 1'b0;
    check_val("ready_latency", {15'd0, ready}, 16'd1);
    check_val("req_dropped", {15'd0, mem_if.mem_req}, 16'd0);
    mio_en = 1'b0;
    step();
    check_val("ready_low", {15'd0, ready}, 16'd0);
  endtask

  initial begin
    bus = 16'h0000; ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0;
    r_w = 1'b0; data_size = SIZE_WORD;
    mem_if.mem_rdata = 16'h0000; mem_if.mem_ready = 1'b0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    check_val("rst_mar", mar, 16'h0000);
    check_val("rst_mdr", mdr, 16'h0000);
    check_val("rst_req", {15'd0, mem_if.mem_req}, 16'd0);
    check_val("rst_we", {14'd0, mem_if.mem_we}, 16'd0);
    check_val("rst_addr", mem_if.mem_addr, 16'h0000);
    check_val("rst_ready", {15'd0, ready}, 16'd0);
    check_val("rst_error", {15'd0, error}, 16'd0);

    // Word read.
    load_mar(16'h3000);
    check_val("mar_load", mar, 16'h3000);
    access(1'b0, SIZE_WORD, 16'hBEEF, 1, 16'h3000, WE_NONE, 16'hBEEF);
    check_val("word_fmt", mdr_fmt, 16'hBEEF);

    // Byte read, odd then even address formatting.
    load_mar(16'h3001);
    access(1'b0, SIZE_BYTE, 16'h80FF, 2, 16'h3000, WE_NONE, 16'h80FF);
    check_val("byte_fmt_hi", mdr_fmt, 16'hFF80);
    load_mar(16'h3000);
    check_val("byte_fmt_lo", mdr_fmt, 16'hFFFF);

    // Byte store from an ld_mdr byte load, then word store.
    bus = 16'h00A5; data_size = SIZE_BYTE; ld_mdr = 1'b1;
    step();
    ld_mdr = 1'b0;
    check_val("mdr_byte_load", mdr, 16'hA5A5);
    load_mar(16'h3001);
    access(1'b1, SIZE_BYTE, 16'h1111, 1, 16'h3000, WE_HI, 16'hA5A5);
    check_val("wdata", mem_if.mem_wdata, 16'hA5A5);
    check_val("store_fmt", mdr_fmt, 16'hFFA5);
    load_mar(16'h3000);
    access(1'b1, SIZE_BYTE, 16'h1111, 3, 16'h3000, WE_LO, 16'hA5A5);
    access(1'b1, SIZE_WORD, 16'h2222, 1, 16'h3000, WE_WORD, 16'hA5A5);

    // ld_mar during ACCESS; mio_en held in DONE.
    req_q.push_back({16'h3000, WE_NONE});
    rsp_q.push_back(16'h1234);
    r_w = 1'b0; data_size = SIZE_WORD; mem_if.mem_rdata = 16'h1234; mio_en = 1'b1;
    step();
    load_mar(16'h4000);
    check_val("addr_held", mem_if.mem_addr, 16'h3000);
    check_val("mar_during_access", mar, 16'h4000);
    mem_if.mem_ready = 1'b1;
    step();
    mem_if.mem_ready = 1'b0;
    repeat (2) step();
    check_val("done_hold_ready", {15'd0, ready}, 16'd1);
    check_val("done_hold_noreq", {15'd0, mem_if.mem_req}, 16'd0);
    mio_en = 1'b0;
    step();

    // Same-edge ld_mar and access start: access uses the old MAR.
    req_q.push_back({16'h4000, WE_NONE});
    rsp_q.push_back(16'h5A5A);
    bus = 16'h5000; ld_mar = 1'b1; mem_if.mem_rdata = 16'h5A5A; mio_en = 1'b1;
    step();
    ld_mar = 1'b0;
    check_val("same_edge_mar", mar, 16'h5000);
    mem_if.mem_ready = 1'b1;
    step();
    mem_if.mem_ready = 1'b0;
    mio_en = 1'b0;
    step();

    // Reset in the middle of a store.
    req_q.push_back({16'h5000, WE_WORD});
    r_w = 1'b1; data_size = SIZE_WORD; mio_en = 1'b1;
    step();
    reset = 1'b1; mio_en = 1'b0;
    step();
    reset = 1'b0;
    check_val("mid_rst_req", {15'd0, mem_if.mem_req}, 16'd0);
    check_val("mid_rst_we", {14'd0, mem_if.mem_we}, 16'd0);
    check_val("mid_rst_mar", mar, 16'h0000);
    check_val("mid_rst_mdr", mdr, 16'h0000);
    step();
    check_val("mid_rst_idle", {15'd0, mem_if.mem_req | ready}, 16'd0);

`ifdef MEM_TIMEOUT_EN
    // No mem_ready: abort after 4 ACCESS cycles, MDR unchanged, sticky error.
    bus = 16'h1357; data_size = SIZE_WORD; ld_mdr = 1'b1;
    step();
    ld_mdr = 1'b0;
    req_q.push_back({16'h0000, WE_NONE});
    rsp_q.push_back(16'h1357);
    r_w = 1'b0; mem_if.mem_rdata = 16'hDEAD; mio_en = 1'b1;
    step();
    repeat (3) step();
    check_val("tmo_not_yet", {15'd0, ready}, 16'd0);
    step();
    check_val("tmo_ready", {15'd0, ready}, 16'd1);
    check_val("tmo_error", {15'd0, error}, 16'd1);
    check_val("tmo_mdr", mdr, 16'h1357);
    mio_en = 1'b0;
    repeat (2) step();
    check_val("tmo_sticky", {15'd0, error}, 16'd1);
`endif

    step();
    check_val("req_queue_empty", 16'(req_q.size()), 16'd0);
    check_val("rsp_queue_empty", 16'(rsp_q.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_port.md
# mem_bus_port

Receiving end of the shared 16-bit datapath bus: captures bus values into MAR and MDR and runs the memory access handshake for LC-3b loads and stores. Bus gate drivers place values on the bus; this block loads them on ld_mar / ld_mdr, performs word or byte accesses, and presents a formatted MDR value for the MDR bus gate. It also produces the R (ready) signal used by the control state machine.

## Interface
- TIMEOUT_CYCLES, 16, cycles in ACCESS without mem_ready before abort (only used with MEM_TIMEOUT_EN)
- clock  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-high
- bus  in  16  shared datapath bus
- ld_mar  in  1  load MAR from bus
- ld_mdr  in  1  load MDR from bus (only when mio_en=0)
- mio_en  in  1  start or hold a memory access
- r_w  in  1  0=read, 1=write; sampled at access start
- data_size  in  1  0=byte, 1=word; sampled at access start and on ld_mdr
- mem_req  out  1  access in progress toward memory
- mem_addr  out  16  word address, bit 0 always 0
- mem_we  out  2  byte write enables {hi,lo}; 2'b00 on reads
- mem_wdata  out  16  store data (MDR)
- mem_rdata  in  16  read data, valid with mem_ready
- mem_ready  in  1  memory completion
- mar  out  16  MAR contents
- mdr  out  16  MDR contents
- mdr_fmt  out  16  value for the MDR gate: word = mdr; byte = sign-extended mdr[15:8] if mar[0] else mdr[7:0]
- ready  out  1  R signal to control
- error  out  1  sticky timeout flag (constant 0 without MEM_TIMEOUT_EN)

## Operation
- States: IDLE, ACCESS, DONE. Reset: state IDLE, mar=0, mdr=0, mem_req=0, mem_we=0, mem_addr=0, ready=0, error=0.
- ld_mar=1 (any state): mar <= bus. mem_addr is not affected during ACCESS.
- ld_mdr=1 and mio_en=0 (any state): word: mdr <= bus; byte: mdr <= {bus[7:0],bus[7:0]}.
- ld_mdr=1 with mio_en=1: ignored; MDR is loaded only by read completion.
- IDLE, mio_en=1: latch r_w, data_size, mem_addr <= {mar[15:1],0}; mem_we: read 00, word write 11, byte write 10 if mar[0] else 01; go ACCESS.
- ACCESS: mem_req=1. On mem_ready=1: read -> mdr <= mem_rdata; go DONE; mem_req and mem_we drop.
- DONE: ready=1. Stay while mio_en=1; go IDLE when mio_en=0. Back-to-back accesses need one mio_en-low cycle.
- Same-edge ld_mar and access start: access uses old mar; new mar visible next cycle.
- Reset mid-ACCESS: mem_req and mem_we drop after that edge; no MDR update.

## Timing
- mio_en high at edge k (IDLE) -> mem_req high after k.
- mem_ready high at edge k+n (n≥1) -> mdr updated and ready high after k+n.
- Minimum latency mio_en to ready: 2 cycles.
- mar/mdr loads visible one cycle after the ld edge; mdr_fmt combinational from mdr, mar, latched data_size.

## Configuration
- MEM_TIMEOUT_EN defined: counter runs in ACCESS; after TIMEOUT_CYCLES cycles without mem_ready -> DONE, mdr unchanged, error <= 1 (sticky until reset); counter cleared on ACCESS entry.
- Undefined: ACCESS waits indefinitely; error tied 0; no counter logic.

## Structure
- lc3b_pkg: state enum (IDLE/ACCESS/DONE), mem_we encodings (WE_NONE, WE_LO, WE_HI, WE_WORD), WORD/BYTE size constants.
- Sub-module mdr_format: combinational byte select and sign extension producing mdr_fmt.

## Test plan
- bus=16'h3000, ld_mar -> mar=3000; mio_en, r_w=0, word, mem_rdata=16'hBEEF with mem_ready 1 cycle after mem_req -> mdr=BEEF, ready high 2 cycles after mio_en, mem_addr=3000.
- mar=16'h3001, byte read, mem_rdata=16'h80FF -> mdr=80FF, mdr_fmt=FF80; mar=3000 -> mdr_fmt=FFFF.
- bus=16'h00A5, ld_mdr byte, mar=3001, write -> mdr=A5A5, mem_we=10, mem_wdata=A5A5; word write -> mem_we=11.
- ld_mar with bus=16'h4000 during ACCESS -> mem_addr stays 3000, mar=4000 after completion; mio_en held in DONE keeps ready=1, no second mem_req.
- Reset asserted in ACCESS -> next cycle mem_req=0, mar=0, mdr=0, state IDLE.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready never -> ready after 4 ACCESS cycles, error=1, mdr unchanged.
